mem_access_unit: RTL

- Initiator side of the word-wide data memory interface.
- Accepts byte-addressed load/store requests from the multicycle control path and converts byte address to word index (byte_addr >> 2).
- Performs sub-word extraction on loads and read-modify-write on sub-word stores.
- Drives the memory's write-enable, address and write data, and samples its combinational read data.

---
 rtl/mem_access_pkg.sv | 49 ++++
 rtl/lane_merge.sv | 38 +++
 rtl/mem_access_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - op/state/size types and op decode helpers for mem_access_unit
package mem_access_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  function automatic logic is_store(op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic is_subword(op_e op);
    return (op != LW) && (op != SW);
  endfunction

  function automatic size_e op_size(op_e op);
    case (op)
      LB, LBU, SB: return SZ_B;
      LH, LHU, SH: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic op_signed(op_e op);
    return (op == LB) || (op == LH);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - little-endian byte/halfword lane insert (stores) and extract/extend (loads)
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [31:0] load_word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] extended
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged = old_word;
    case (size)
      SZ_B:    merged[{lane, 3'b000} +: 8] = new_data[7:0];
      SZ_H:    merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

  // Halfword lane is chosen by lane[1]; alignment is checked upstream.
  always_comb begin
    byte_sel = load_word[{lane, 3'b000} +: 8];
    half_sel = load_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    extended = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_H:    extended = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: extended = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - word-memory initiator: byte-addressed load/store with sub-word RMW
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 100,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [AW-1:0] byte_addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  state_e      state, state_next;
  op_e         op_in, op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;
  logic [31:0] merged;
  logic [31:0] extended;
  logic        bad_req;

  assign op_in = op_e'(op);

  always_comb begin
    bad_req = 1'b0;
    if ((op_size(op_in) == SZ_H) && byte_addr[0])
      bad_req = 1'b1;
    if ((op_size(op_in) == SZ_W) && (byte_addr[1:0] != 2'b00))
      bad_req = 1'b1;
    if ((byte_addr >> 2) >= AW'(DEPTH_WORDS))
      bad_req = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= LW;
      lane_q   <= 2'b00;
      wdata_q  <= 32'd0;
      rd_q     <= 32'd0;
      mem_addr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        op_q     <= op_in;
        lane_q   <= byte_addr[1:0];
        wdata_q  <= wdata;
        mem_addr <= byte_addr >> 2;
      end
      if (state == READ)
        rd_q <= mem_rd;
    end
  end

  lane_merge u_lane_merge (
    .old_word  (rd_q),
    .new_data  (wdata_q),
    .load_word (rd_q),
    .lane      (lane_q),
    .size      (op_size(op_q)),
    .sign_ext  (op_signed(op_q)),
    .merged    (merged),
    .extended  (extended)
  );

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    rdata      = 32'd0;
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req)
          state_next = bad_req ? ERR : ((op_in == SW) ? WRITE : READ);
      end
      READ: state_next = is_store(op_q) ? WRITE : DONE;
      WRITE: begin
        mem_we     = 1'b1;
        mem_wd     = merged;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        rdata      = is_store(op_q) ? 32'd0 : extended;
        state_next = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
